// File: rtl/pipe_stage_skid_if.sv
// rtl/pipe_stage_skid_if.sv - valid/ready payload handshake bundle for pipe_stage_skid
interface pipe_stage_skid_if #(
  parameter int WIDTH = 56
) ();
  logic             valid;
  logic [WIDTH-1:0] data;
  logic             ready;

  // Producer side: drives payload and valid, observes ready.
  modport master (
    output valid,
    output data,
    input  ready
  );

  // Consumer side: observes payload and valid, drives ready.
  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - two-entry registered pipeline stage with skid buffer, stall and flush
module pipe_stage_skid #(
  parameter int               WIDTH  = 56,
  parameter int               NGO    = 2,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int               CNT_W  = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic [NGO-1:0]   go_i,
  pipe_stage_skid_if.slave up_if,
  pipe_stage_skid_if.master dn_if,
  output logic [1:0]       occ_o,
  output logic [CNT_W-1:0] drop_cnt_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic             go_all;
  logic             in_ready;
  logic             out_valid;
  logic             accept;
  logic             take;
  logic [1:0]       occ;
  logic [CNT_W+1:0] drop_sum;

  // All stage enables must agree before anything moves.
  assign go_all = &go_i;

  // Readiness depends only on registered state plus go/clear/rst, never on
  // downstream ready, so no combinational path runs through the stage.
  // Held low during reset so upstream never sees a handshake before the
  // stage comes out of reset.
  assign in_ready  = (state_q != ST_FULL) & go_all & ~clear_i & ~rst_i;
  assign out_valid = (state_q != ST_EMPTY) & go_all & ~clear_i & ~rst_i;

  assign accept = up_if.valid & in_ready;
  assign take   = out_valid & dn_if.ready;

  assign up_if.ready = in_ready;
  assign dn_if.valid = out_valid;
  // Main register is the head; force the bubble while reset is still being
  // applied so the register's pre-reset contents never leak downstream.
  assign dn_if.data  = rst_i ? BUBBLE : main_q;

  // Occupancy decoded from the registered state only.
  always_comb begin
    occ = 2'd0;
    case (state_q)
      ST_ONE:  occ = 2'd1;
      ST_FULL: occ = 2'd2;
      default: occ = 2'd0;
    endcase
  end

  assign occ_o      = occ;
  assign drop_cnt_o = drop_q;

  // Widened sum so the saturation test cannot itself overflow.
  assign drop_sum = {2'b00, drop_q} + {{CNT_W{1'b0}}, occ};

  // Next-state and next-data selection; flush overrides any handshake.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    drop_d  = drop_q;

    if (clear_i) begin
      state_d = ST_EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
      drop_d  = (drop_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : drop_sum[CNT_W-1:0];
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            main_d  = up_if.data;
          end
        end

        ST_ONE: begin
          if (accept && take) begin
            main_d = up_if.data;
          end else if (accept) begin
            state_d = ST_FULL;
            skid_d  = up_if.data;
          end else if (take) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE;
          end
        end

        ST_FULL: begin
          // in_ready is low here, so only the head can leave.
          if (take) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = BUBBLE;
          end
        end

        default: begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end
  end

  // State and payload registers; reset wins over flush, go and handshakes
  // and deliberately does not count discarded entries.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL expose parameter WIDTH, default 56, payload bits per entry (covers pc_4 + instruction + addr = 12+32+12).
REQ-002 SHALL expose parameter NGO, default 2, number of independent stage-enable inputs.
REQ-003 SHALL expose parameter BUBBLE, default all-zero WIDTH-bit constant, payload value presented when the stage is empty or flushed.
REQ-004 SHALL expose parameter CNT_W, default 8, width of the flush-drop counter.
REQ-005 SHALL have a single clock; reset is synchronous and active-high.
REQ-006 clk  input  1  clock; all state updates on posedge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 clear  input  1  flush request; discards all held entries.
REQ-009 go  input  NGO  stage enables; stage advances only when all bits are 1 (go_all = AND of go).
REQ-010 in_valid  input  1  upstream payload valid.
REQ-011 in_data  input  WIDTH  upstream payload.
REQ-012 in_ready  output  1  stage accepts in_data this cycle.
REQ-013 out_valid  output  1  out_data holds a valid entry.
REQ-014 out_data  output  WIDTH  head-entry payload.
REQ-015 out_ready  input  1  downstream consumes the head entry this cycle.
REQ-016 occ  output  2  entries held: 0, 1 or 2.
REQ-017 drop_cnt  output  CNT_W  valid entries discarded by clear; saturating.

Function
REQ-018 The stage SHALL hold two registered entries: main (head) and skid; states EMPTY (occ=0), ONE (main valid), FULL (main+skid valid).
REQ-019 in_ready SHALL equal (state != FULL) & go_all & ~clear, combinationally from registered state and inputs; there is no combinational path from out_ready to in_ready.
REQ-020 out_valid SHALL equal main_valid & go_all & ~clear; out_data SHALL equal the main register at all times.
REQ-021 Accept = in_valid & in_ready; Take = out_valid & out_ready.
REQ-022 EMPTY: Accept -> ONE, main <= in_data.
REQ-023 ONE: Accept & Take -> ONE, main <= in_data; Accept only -> FULL, skid <= in_data; Take only -> EMPTY, main <= BUBBLE; neither -> hold.
REQ-024 FULL: Take -> ONE, main <= skid, skid <= BUBBLE; no Take -> hold; Accept cannot occur.
REQ-025 When go_all = 0 and clear = 0, all state and data SHALL hold unchanged regardless of in_valid/out_ready.
REQ-026 Latency: an entry accepted into an EMPTY stage SHALL appear on out_valid/out_data the next cycle; FIFO order SHALL be preserved.
REQ-027 clear = 1 (independent of go) SHALL, next cycle, set state EMPTY, main and skid to BUBBLE, occ = 0; clear overrides any simultaneous Accept/Take (neither occurs).
REQ-028 On clear, drop_cnt SHALL add occ (0, 1 or 2) and saturate at 2^CNT_W-1.
REQ-029 occ SHALL reflect registered state only.

Reset
REQ-030 rst = 1 at posedge SHALL set state EMPTY, main = skid = BUBBLE, occ = 0, drop_cnt = 0; rst has priority over clear, go and handshakes.
REQ-031 While rst = 1: out_valid = 0, out_data = BUBBLE; in_ready SHALL follow REQ-019 from the reset state only after rst deasserts.
REQ-032 Reset asserted mid-operation with occ = 2 SHALL discard both entries without incrementing drop_cnt.

Verification
REQ-033 Streaming: go = 2'b11, out_ready = 1, in_data = 1,2,3 on consecutive cycles -> out_data 1,2,3 one cycle later each, occ stays 1.
REQ-034 Backpressure: out_ready = 0, push A then B -> occ = 2, in_ready = 0, C not accepted; then out_ready = 1 -> A, B out in order, occ 2->1->0.
REQ-035 Stall: go = 2'b10 with in_valid = 1, out_ready = 1 for 3 cycles -> in_ready = 0, out_valid = 0, occ and out_data unchanged.
REQ-036 Flush: occ = 2, clear = 1 with in_valid = 1, out_ready = 1 -> next cycle occ = 0, out_data = BUBBLE, drop_cnt += 2, input not accepted.
REQ-037 Saturation: CNT_W = 2, four clears at occ = 1 -> drop_cnt 1,2,3,3.
REQ-038 Reset: rst = 1 with occ = 2 and clear = 1 -> occ = 0, out_data = BUBBLE, drop_cnt = 0.
